// File: rtl/conv_frame_loader_if.sv
// Sample-stream / frame handshake bundle for conv_frame_loader.
// master = upstream/downstream environment, slave = the loader itself.
interface conv_frame_loader_if #(
    parameter int W = 4,
    parameter int N = 8
);
    logic           flush;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           frame_ack;
    logic           frame_valid;
    logic [N*W-1:0] x_flat;
    logic [N*W-1:0] h_flat;
    logic           busy;

    modport master (
        output flush, in_valid, in_data, frame_ack,
        input  in_ready, frame_valid, x_flat, h_flat, busy
    );

    modport slave (
        input  flush, in_valid, in_data, frame_ack,
        output in_ready, frame_valid, x_flat, h_flat, busy
    );
endinterface

// File: rtl/conv_frame_loader.sv
// Collects N x samples then N h samples into flat frame registers for a convolver.
// Optional CONV_LOADER_CHKSUM_EN adds an 8-bit mod-256 checksum output of the frame.
//
// state  | meaning
// LOAD_X | accepting x[0..N-1]
// LOAD_H | accepting h[0..N-1]
// HOLD   | frame complete, waiting for frame_ack
module conv_frame_loader #(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    conv_frame_loader_if.slave  bus
`ifdef CONV_LOADER_CHKSUM_EN
    ,
    output logic [7:0]          chksum
`endif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_H = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [N-1:0][W-1:0]    x_q;
    logic [N-1:0][W-1:0]    h_q;
    logic                   frame_valid_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   accept;
    logic                   last_idx;

    assign accept   = bus.in_valid && in_ready_q;
    assign last_idx = (idx_q == IW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD_X;
            idx_q         <= '0;
            x_q           <= '0;
            h_q           <= '0;
            frame_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else if (bus.flush) begin
            // Abort wins over accept/ack; sample arrays are deliberately left alone.
            state_q       <= LOAD_X;
            idx_q         <= '0;
            frame_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                LOAD_X: begin
                    if (accept) begin
                        x_q[idx_q] <= bus.in_data;
                        busy_q     <= 1'b1;
                        if (last_idx) begin
                            state_q <= LOAD_H;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                LOAD_H: begin
                    if (accept) begin
                        h_q[idx_q] <= bus.in_data;
                        if (last_idx) begin
                            state_q       <= HOLD;
                            idx_q         <= '0;
                            frame_valid_q <= 1'b1;
                            in_ready_q    <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.frame_ack) begin
                        state_q       <= LOAD_X;
                        frame_valid_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= LOAD_X;
                    idx_q         <= '0;
                    frame_valid_q <= 1'b0;
                    in_ready_q    <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = busy_q;
    assign bus.x_flat      = x_q;
    assign bus.h_flat      = h_q;

`ifdef CONV_LOADER_CHKSUM_EN
    logic [7:0] sum_q;

    // Cleared whenever a new frame starts so the sum covers exactly 2N samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (bus.flush) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + 8'(bus.in_data);
        end else if (state_q == HOLD && bus.frame_ack) begin
            sum_q <= '0;
        end
    end

    assign chksum = sum_q;
`endif
endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: vector table, hand sequences and a frame scoreboard.
module tb_conv_frame_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    conv_frame_loader_if #(.W(4), .N(8)) bus ();
`ifdef CONV_LOADER_CHKSUM_EN
    logic [7:0] chksum;
    conv_frame_loader #(.W(4), .N(8)) dut (.clk(clk), .rst(rst), .bus(bus), .chksum(chksum));
`else
    conv_frame_loader #(.W(4), .N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        logic [31:0] x;
        logic [31:0] h;
        logic [7:0]  s;
    } frame_t;
    frame_t sb[$];

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       ack;
        logic       e_fv;
        logic       e_rdy;
        logic       e_busy;
    } vec_t;
    vec_t tbl[28];

    // reference model
    int         m_state = 0;   // 0 x, 1 h, 2 hold
    int         m_idx   = 0;
    logic [3:0] mx[8];
    logic [3:0] mh[8];
    logic [7:0] m_sum   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] a[8]);
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[k*4 +: 4] = a[k];
        return r;
    endfunction

    function automatic logic m_ready();  return m_state != 2; endfunction
    function automatic logic m_fv();     return m_state == 2; endfunction
    function automatic logic m_busy();   return m_state == 1 || (m_state == 0 && m_idx != 0); endfunction

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_sum = 0;
        for (int k = 0; k < 8; k++) begin mx[k] = 4'h0; mh[k] = 4'h0; end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic fl, input logic ack);
        logic acc;
        frame_t f;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.frame_ack = ack;
        @(posedge clk);
        acc = v && m_ready();
        if (fl) begin
            m_state = 0; m_idx = 0; m_sum = 0;
        end else begin
            case (m_state)
                0: if (acc) begin
                    mx[m_idx] = d; m_sum = m_sum + 8'(d);
                    if (m_idx == 7) begin m_state = 1; m_idx = 0; end else m_idx++;
                end
                1: if (acc) begin
                    mh[m_idx] = d; m_sum = m_sum + 8'(d);
                    if (m_idx == 7) begin
                        m_state = 2; m_idx = 0;
                        f.x = pack(mx); f.h = pack(mh); f.s = m_sum;
                        sb.push_back(f);
                    end else m_idx++;
                end
                default: if (ack) begin m_state = 0; m_sum = 0; end
            endcase
        end
        #1;
        chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv()));
        chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
        chk("busy", 64'(bus.busy), 64'(m_busy()));
        chk("x_flat", 64'(bus.x_flat), 64'(pack(mx)));
        chk("h_flat", 64'(bus.h_flat), 64'(pack(mh)));
        bus.flush     = 1'b0;
        bus.frame_ack = 1'b0;
    endtask

    task automatic rst_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_x_flat", 64'(bus.x_flat), 64'h0);
        chk("rst_h_flat", 64'(bus.h_flat), 64'h0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        model_reset();
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.frame_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 64'(bus.in_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // frame monitor: pops the scoreboard on each rising frame_valid
    logic prev_fv = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.frame_valid && !prev_fv) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_frame: got x=%h h=%h expected no frame", bus.x_flat, bus.h_flat);
            end else begin
                frame_t f;
                f = sb.pop_front();
                if (bus.x_flat !== f.x || bus.h_flat !== f.h) begin
                    errors++;
                    $display("FAIL sb_frame: got x=%h h=%h expected x=%h h=%h", bus.x_flat, bus.h_flat, f.x, f.h);
                end
`ifdef CONV_LOADER_CHKSUM_EN
                chk("sb_chksum", 64'(chksum), 64'(f.s));
`endif
            end
        end
        prev_fv = bus.frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // vector table: full frame 1..F,0, ten back-pressure cycles, ack, next sample
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 4'((i + 1) % 16), 1'b0, (i == 15), (i != 15), (i < 15)};
        for (int i = 16; i < 26; i++)
            tbl[i] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[27] = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1};

        bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.flush = 1'b0; bus.frame_ack = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("init_x_flat", 64'(bus.x_flat), 64'h0);
        chk("init_h_flat", 64'(bus.h_flat), 64'h0);
        chk("init_frame_valid", 64'(bus.frame_valid), 64'h0);
        chk("init_in_ready", 64'(bus.in_ready), 64'h1);
        chk("init_busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0, tbl[i].ack);
            chk("tbl_frame_valid", 64'(bus.frame_valid), 64'(tbl[i].e_fv));
            chk("tbl_in_ready", 64'(bus.in_ready), 64'(tbl[i].e_rdy));
            chk("tbl_busy", 64'(bus.busy), 64'(tbl[i].e_busy));
            if (i == 15) begin
                chk("full_x_flat", 64'(bus.x_flat), 64'h87654321);
                chk("full_h_flat", 64'(bus.h_flat), 64'h0FEDCBA9);
            end
            if (i == 25) chk("hold_x_stable", 64'(bus.x_flat), 64'h87654321);
        end
        chk("after_ack_x0", 64'(bus.x_flat), 64'h87654329);
        chk("after_ack_h", 64'(bus.h_flat), 64'h0FEDCBA9);

        // flush with a same-cycle sample after 5 x accepts
        for (int i = 0; i < 4; i++) step(1'b1, 4'(10 + i), 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0);
        chk("flush_x_kept", 64'(bus.x_flat), 64'h876DCBA9);
        chk("flush_busy", 64'(bus.busy), 64'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i + 2), 1'b0, 1'b0);
            if (i == 14) chk("flush_15_no_fv", 64'(bus.frame_valid), 64'h0);
        end
        chk("flush_16_fv", 64'(bus.frame_valid), 64'h1);
        chk("flush_x_restart", 64'(bus.x_flat[3:0]), 64'h2);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // all-F frame, then flush in HOLD with ack and sample on the same cycle
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
        chk("allf_fv", 64'(bus.frame_valid), 64'h1);
`ifdef CONV_LOADER_CHKSUM_EN
        chk("chksum_allf", 64'(chksum), 64'hF0);
`endif
        step(1'b1, 4'h5, 1'b1, 1'b1);
        chk("flush_hold_fv", 64'(bus.frame_valid), 64'h0);
        chk("flush_hold_x", 64'(bus.x_flat), 64'hFFFFFFFF);

        // reset after 8 x and 3 h samples, then a fresh random frame
        for (int i = 0; i < 11; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        rst_mid();
        for (int i = 0; i < 16; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        chk("post_rst_fv", 64'(bus.frame_valid), 64'h1);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);

        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
